// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC capture sequencer.
//   seq_state_e : FSM state encoding (also visible on FSM_STATE for debug)
//   ch_w()      : channel-select width, never below 1 bit
//   tmr_w()     : width of the shared down-counter for the given cycle counts
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAITING = 3'b000,
        ST_RST     = 3'b001,
        ST_STOPPED = 3'b011,
        ST_WRITE   = 3'b100,
        ST_HOLD    = 3'b110
    } seq_state_e;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The counter only ever holds (cycles - 1), so $clog2(max) bits suffice.
    function automatic int tmr_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/adc_seq_if.sv
// Bundles the ADC handshake and channel-register strobes of the sequencer.
//   master : the sequencer (drives strobes/status, receives enable/mode/done)
//   slave  : the ADC / register-file side
interface adc_seq_if
    import adc_seq_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
);
    localparam int CH_W = ch_w(N_CH);

    logic              enable;
    logic              single_shot;
    logic              done;
    logic [N_CH-1:0]   REG_WRITE;
    logic              REG_RST;
    logic              ADC_RST;
    logic [CH_W-1:0]   ch_sel;
    logic              frame_done;
    logic [CNT_W-1:0]  sample_cnt;
    logic              busy;
    logic              timeout_err;
    logic              overrun_err;
    logic [2:0]        FSM_STATE;

    modport master (
        input  enable, single_shot, done,
        output REG_WRITE, REG_RST, ADC_RST, ch_sel, frame_done, sample_cnt,
               busy, timeout_err, overrun_err, FSM_STATE
    );

    modport slave (
        output enable, single_shot, done,
        input  REG_WRITE, REG_RST, ADC_RST, ch_sel, frame_done, sample_cnt,
               busy, timeout_err, overrun_err, FSM_STATE
    );

endinterface

// File: rtl/done_edge_sync.sv
// Two-flop synchroniser for an asynchronous level plus rising-edge detect.
//   clk      : sampling clock
//   rst_n    : synchronous active-low reset
//   async_i  : asynchronous level input
//   rise_o   : registered one-cycle pulse per rising edge of async_i
// The edge pulse is registered so that consumers see a glitch-free flop
// output; a level first sampled at edge t gives rise_o high after edge t+2.
module done_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic s1_q, s2_q, s3_q, rise_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= async_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/adc_capture_sequencer.sv
// Round-robin ADC capture sequencer: waits for a conversion-done edge,
// strobes the per-channel register write, then pulses the ADC reset.
//   adc_clk : sole clock
//   rst_n   : synchronous active-low reset
//   bus     : adc_seq_if.master (enable, single_shot, done in; strobes,
//             channel select, counters, error flags and debug state out)
//
// state   | meaning
// STOPPED | idle, channel registers and ADC held in reset
// WAITING | waiting for done edge, timeout timer running
// WRITE   | REG_WRITE[ch_sel] strobe for WRITE_CYCLES cycles
// RST     | ADC_RST pulse for RST_CYCLES cycles, then advance channel
// HOLD    | single-shot frame complete, frozen until enable drops
module adc_capture_sequencer
    import adc_seq_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int WRITE_CYCLES   = 1,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic      adc_clk,
    input  logic      rst_n,
    adc_seq_if.master bus
);

    localparam int CH_W = ch_w(N_CH);
    localparam int TM_W = tmr_w(WRITE_CYCLES, RST_CYCLES, TIMEOUT_CYCLES);

    localparam logic [TM_W-1:0] WR_LOAD = TM_W'(WRITE_CYCLES - 1);
    localparam logic [TM_W-1:0] RS_LOAD = TM_W'(RST_CYCLES - 1);
    localparam logic [TM_W-1:0] TO_LOAD =
        (TIMEOUT_CYCLES > 0) ? TM_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    logic done_rise;

    done_edge_sync u_done_sync (
        .clk     (adc_clk),
        .rst_n   (rst_n),
        .async_i (bus.done),
        .rise_o  (done_rise)
    );

    seq_state_e       state_q, state_d;
    logic [TM_W-1:0]  tmr_q, tmr_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_pass_q, to_pass_d;   // current RST pass is a timeout recovery
    logic             to_err_q, to_err_d;
    logic             ov_err_q, ov_err_d;
    logic             frame_q, frame_d;
    logic [N_CH-1:0]  reg_write_q, reg_write_d;
    logic             reg_rst_q, reg_rst_d;
    logic             adc_rst_q, adc_rst_d;
    logic             busy_q, busy_d;

    always_ff @(posedge adc_clk) begin
        if (!rst_n) begin
            state_q     <= ST_STOPPED;
            tmr_q       <= '0;
            ch_q        <= '0;
            cnt_q       <= '0;
            to_pass_q   <= 1'b0;
            to_err_q    <= 1'b0;
            ov_err_q    <= 1'b0;
            frame_q     <= 1'b0;
            reg_write_q <= '0;
            reg_rst_q   <= 1'b1;
            adc_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            to_pass_q   <= to_pass_d;
            to_err_q    <= to_err_d;
            ov_err_q    <= ov_err_d;
            frame_q     <= frame_d;
            reg_write_q <= reg_write_d;
            reg_rst_q   <= reg_rst_d;
            adc_rst_q   <= adc_rst_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        to_pass_d = to_pass_q;
        to_err_d  = to_err_q;
        ov_err_d  = ov_err_q;
        frame_d   = 1'b0;

        if (done_rise && (state_q == ST_WRITE || state_q == ST_RST ||
                          state_q == ST_HOLD))
            ov_err_d = 1'b1;

        if (!bus.enable) begin
            state_d = ST_STOPPED;
        end else begin
            case (state_q)
                ST_STOPPED: begin
                    state_d  = ST_WAITING;
                    tmr_d    = TO_LOAD;
                    ch_d     = '0;
                    to_err_d = 1'b0;
                end
                ST_WAITING: begin
                    // done edge has priority over a coincident timeout
                    if (done_rise) begin
                        state_d   = ST_WRITE;
                        tmr_d     = WR_LOAD;
                        to_pass_d = 1'b0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        if (tmr_q == '0) begin
                            state_d   = ST_RST;
                            tmr_d     = RS_LOAD;
                            to_pass_d = 1'b1;
                            to_err_d  = 1'b1;
                        end else begin
                            tmr_d = tmr_q - TM_W'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    if (tmr_q == '0) begin
                        state_d = ST_RST;
                        tmr_d   = RS_LOAD;
                    end else begin
                        tmr_d = tmr_q - TM_W'(1);
                    end
                end
                ST_RST: begin
                    if (tmr_q == '0) begin
                        tmr_d   = TO_LOAD;
                        state_d = ST_WAITING;
                        if (to_pass_q) begin
                            to_pass_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                            if (ch_q == LAST_CH) begin
                                ch_d    = '0;
                                frame_d = 1'b1;
                                if (bus.single_shot)
                                    state_d = ST_HOLD;
                            end else begin
                                ch_d = ch_q + CH_W'(1);
                            end
                        end
                    end else begin
                        tmr_d = tmr_q - TM_W'(1);
                    end
                end
                ST_HOLD: begin
                    state_d = ST_HOLD;
                end
                default: begin
                    state_d = ST_STOPPED;
                end
            endcase
        end
    end

    // Moore outputs decoded from the next state so they register in step
    // with the state they belong to.
    always_comb begin
        reg_write_d = '0;
        for (int i = 0; i < N_CH; i++)
            reg_write_d[i] = (state_d == ST_WRITE) && (ch_d == CH_W'(i));
        reg_rst_d = (state_d == ST_STOPPED);
        adc_rst_d = (state_d == ST_STOPPED) || (state_d == ST_RST);
        busy_d    = (state_d == ST_WRITE) || (state_d == ST_RST);
    end

    assign bus.REG_WRITE   = reg_write_q;
    assign bus.REG_RST     = reg_rst_q;
    assign bus.ADC_RST     = adc_rst_q;
    assign bus.ch_sel      = ch_q;
    assign bus.frame_done  = frame_q;
    assign bus.sample_cnt  = cnt_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = to_err_q;
    assign bus.overrun_err = ov_err_q;
    assign bus.FSM_STATE   = state_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer.
//   dut_a : N_CH=4, WRITE=1, RST=2, TIMEOUT=16 (capture, frame, hold, timeout)
//   dut_b : N_CH=4, WRITE=4, RST=2, TIMEOUT=0  (long write abort, mid-RST reset)
module tb_adc_capture_sequencer;

    localparam logic [2:0] S_WAIT = 3'b000;
    localparam logic [2:0] S_RST  = 3'b001;
    localparam logic [2:0] S_STOP = 3'b011;
    localparam logic [2:0] S_WR   = 3'b100;
    localparam logic [2:0] S_HOLD = 3'b110;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    adc_seq_if #(.N_CH(4), .CNT_W(16)) bus_a ();
    adc_seq_if #(.N_CH(4), .CNT_W(16)) bus_b ();

    adc_capture_sequencer #(
        .N_CH(4), .WRITE_CYCLES(1), .RST_CYCLES(2), .TIMEOUT_CYCLES(16), .CNT_W(16)
    ) dut_a (
        .adc_clk (clk),
        .rst_n   (rst_a),
        .bus     (bus_a)
    );

    adc_capture_sequencer #(
        .N_CH(4), .WRITE_CYCLES(4), .RST_CYCLES(2), .TIMEOUT_CYCLES(0), .CNT_W(16)
    ) dut_b (
        .adc_clk (clk),
        .rst_n   (rst_b),
        .bus     (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One capture on dut_a from WAITING: done pulse, WRITE, 2-cycle RST, exit.
    task automatic capture_a(input string tag, input logic [3:0] exp_wr,
                             input logic [2:0] exp_state, input logic exp_frame,
                             input logic [1:0] exp_ch, input logic [15:0] exp_cnt);
        bus_a.done = 1'b1;
        tick();
        bus_a.done = 1'b0;
        tick();
        tick();
        chk({tag, ".pre_state"}, bus_a.FSM_STATE, S_WAIT);
        tick();
        chk({tag, ".wr_state"}, bus_a.FSM_STATE, S_WR);
        chk({tag, ".wr"}, bus_a.REG_WRITE, exp_wr);
        chk({tag, ".wr_busy"}, bus_a.busy, 1'b1);
        tick();
        chk({tag, ".rst1_state"}, bus_a.FSM_STATE, S_RST);
        chk({tag, ".rst1_wr"}, bus_a.REG_WRITE, 4'b0000);
        chk({tag, ".rst1_adc"}, bus_a.ADC_RST, 1'b1);
        tick();
        chk({tag, ".rst2_adc"}, bus_a.ADC_RST, 1'b1);
        tick();
        chk({tag, ".exit_state"}, bus_a.FSM_STATE, exp_state);
        chk({tag, ".exit_adc"}, bus_a.ADC_RST, 1'b0);
        chk({tag, ".ch"}, bus_a.ch_sel, exp_ch);
        chk({tag, ".cnt"}, bus_a.sample_cnt, exp_cnt);
        chk({tag, ".frame"}, bus_a.frame_done, exp_frame);
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, ".state"}, bus_a.FSM_STATE, S_STOP);
        chk({tag, ".regrst"}, bus_a.REG_RST, 1'b1);
        chk({tag, ".adcrst"}, bus_a.ADC_RST, 1'b1);
        chk({tag, ".wr"}, bus_a.REG_WRITE, 4'b0000);
        chk({tag, ".ch"}, bus_a.ch_sel, 2'd0);
        chk({tag, ".cnt"}, bus_a.sample_cnt, 16'd0);
        chk({tag, ".frame"}, bus_a.frame_done, 1'b0);
        chk({tag, ".busy"}, bus_a.busy, 1'b0);
        chk({tag, ".to"}, bus_a.timeout_err, 1'b0);
        chk({tag, ".ov"}, bus_a.overrun_err, 1'b0);
    endtask

    task automatic check_reset_b(input string tag);
        chk({tag, ".state"}, bus_b.FSM_STATE, S_STOP);
        chk({tag, ".regrst"}, bus_b.REG_RST, 1'b1);
        chk({tag, ".adcrst"}, bus_b.ADC_RST, 1'b1);
        chk({tag, ".wr"}, bus_b.REG_WRITE, 4'b0000);
        chk({tag, ".ch"}, bus_b.ch_sel, 2'd0);
        chk({tag, ".cnt"}, bus_b.sample_cnt, 16'd0);
        chk({tag, ".busy"}, bus_b.busy, 1'b0);
        chk({tag, ".ov"}, bus_b.overrun_err, 1'b0);
    endtask

    // dut_b: done pulse from WAITING, returns in first WRITE cycle
    task automatic enter_write_b(input string tag);
        bus_b.done = 1'b1;
        tick();
        bus_b.done = 1'b0;
        tick();
        tick();
        tick();
        chk({tag, ".state"}, bus_b.FSM_STATE, S_WR);
        chk({tag, ".wr"}, bus_b.REG_WRITE, 4'b0001);
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.enable = 1'b0; bus_a.single_shot = 1'b0; bus_a.done = 1'b0;
        bus_b.enable = 1'b0; bus_b.single_shot = 1'b0; bus_b.done = 1'b0;
        tick();
        tick();
        check_reset_a("rst_a");
        check_reset_b("rst_b");

        // 1/2: continuous frame walking all four channels
        rst_a = 1'b1;
        bus_a.enable = 1'b1;
        tick();
        chk("en.state", bus_a.FSM_STATE, S_WAIT);
        chk("en.regrst", bus_a.REG_RST, 1'b0);
        chk("en.adcrst", bus_a.ADC_RST, 1'b0);
        capture_a("c0", 4'b0001, S_WAIT, 1'b0, 2'd1, 16'd1);
        capture_a("c1", 4'b0010, S_WAIT, 1'b0, 2'd2, 16'd2);
        capture_a("c2", 4'b0100, S_WAIT, 1'b0, 2'd3, 16'd3);
        capture_a("c3", 4'b1000, S_WAIT, 1'b1, 2'd0, 16'd4);
        tick();
        chk("c3.frame_end", bus_a.frame_done, 1'b0);
        chk("c3.no_ov", bus_a.overrun_err, 1'b0);

        // 3: single-shot frame ends in HOLD, extra done is an overrun
        bus_a.single_shot = 1'b1;
        capture_a("s0", 4'b0001, S_WAIT, 1'b0, 2'd1, 16'd5);
        capture_a("s1", 4'b0010, S_WAIT, 1'b0, 2'd2, 16'd6);
        capture_a("s2", 4'b0100, S_WAIT, 1'b0, 2'd3, 16'd7);
        capture_a("s3", 4'b1000, S_HOLD, 1'b1, 2'd0, 16'd8);
        chk("hold.regrst", bus_a.REG_RST, 1'b0);
        chk("hold.ov0", bus_a.overrun_err, 1'b0);
        bus_a.done = 1'b1;
        tick();
        bus_a.done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold.wr", bus_a.REG_WRITE, 4'b0000);
        end
        chk("hold.state", bus_a.FSM_STATE, S_HOLD);
        chk("hold.ov", bus_a.overrun_err, 1'b1);
        chk("hold.cnt", bus_a.sample_cnt, 16'd8);
        bus_a.enable = 1'b0;
        tick();
        chk("stop.state", bus_a.FSM_STATE, S_STOP);
        chk("stop.regrst", bus_a.REG_RST, 1'b1);
        chk("stop.adcrst", bus_a.ADC_RST, 1'b1);
        chk("stop.ov_sticky", bus_a.overrun_err, 1'b1);

        // 4: timeout recovery after 16 WAITING cycles
        bus_a.single_shot = 1'b0;
        bus_a.enable = 1'b1;
        tick();
        chk("to.state0", bus_a.FSM_STATE, S_WAIT);
        chk("to.cnt_kept", bus_a.sample_cnt, 16'd8);
        for (int i = 0; i < 15; i++) tick();
        chk("to.last_wait", bus_a.FSM_STATE, S_WAIT);
        chk("to.no_err_yet", bus_a.timeout_err, 1'b0);
        tick();
        chk("to.rst_state", bus_a.FSM_STATE, S_RST);
        chk("to.adc1", bus_a.ADC_RST, 1'b1);
        chk("to.err", bus_a.timeout_err, 1'b1);
        chk("to.wr", bus_a.REG_WRITE, 4'b0000);
        tick();
        chk("to.adc2", bus_a.ADC_RST, 1'b1);
        tick();
        chk("to.exit_state", bus_a.FSM_STATE, S_WAIT);
        chk("to.ch", bus_a.ch_sel, 2'd0);
        chk("to.cnt", bus_a.sample_cnt, 16'd8);
        chk("to.frame", bus_a.frame_done, 1'b0);
        capture_a("to_cap", 4'b0001, S_WAIT, 1'b0, 2'd1, 16'd9);
        chk("to.err_sticky", bus_a.timeout_err, 1'b1);

        // 5: done already high when enable rises must not trigger
        bus_a.enable = 1'b0;
        tick();
        bus_a.done = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus_a.enable = 1'b1;
        tick();
        chk("lvl.to_clr", bus_a.timeout_err, 1'b0);
        chk("lvl.ch_clr", bus_a.ch_sel, 2'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("lvl.state", bus_a.FSM_STATE, S_WAIT);
        chk("lvl.wr", bus_a.REG_WRITE, 4'b0000);
        chk("lvl.cnt", bus_a.sample_cnt, 16'd9);
        bus_a.done = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        capture_a("lvl_cap", 4'b0001, S_WAIT, 1'b0, 2'd1, 16'd10);
        bus_a.enable = 1'b0;
        rst_a = 1'b0;
        tick();
        check_reset_a("rst_a2");

        // 6: dut_b long write, abort mid-WRITE, reset mid-RST, no timeout
        rst_b = 1'b1;
        bus_b.enable = 1'b1;
        tick();
        enter_write_b("b0");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b0.wr_hold", bus_b.REG_WRITE, 4'b0001);
        end
        tick();
        chk("b0.rst_state", bus_b.FSM_STATE, S_RST);
        chk("b0.rst_wr", bus_b.REG_WRITE, 4'b0000);
        tick();
        tick();
        chk("b0.exit", bus_b.FSM_STATE, S_WAIT);
        chk("b0.cnt", bus_b.sample_cnt, 16'd1);
        chk("b0.ch", bus_b.ch_sel, 2'd1);
        bus_b.done = 1'b1;
        tick();
        bus_b.done = 1'b0;
        tick();
        tick();
        tick();
        chk("b1.wr", bus_b.REG_WRITE, 4'b0010);
        tick();
        bus_b.enable = 1'b0;
        tick();
        chk("abort.state", bus_b.FSM_STATE, S_STOP);
        chk("abort.wr", bus_b.REG_WRITE, 4'b0000);
        chk("abort.regrst", bus_b.REG_RST, 1'b1);
        chk("abort.adcrst", bus_b.ADC_RST, 1'b1);
        chk("abort.busy", bus_b.busy, 1'b0);
        chk("abort.cnt", bus_b.sample_cnt, 16'd1);

        bus_b.enable = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) tick();
        chk("noto.state", bus_b.FSM_STATE, S_WAIT);
        chk("noto.err", bus_b.timeout_err, 1'b0);
        enter_write_b("b2");
        for (int i = 0; i < 4; i++) tick();
        chk("b2.rst_state", bus_b.FSM_STATE, S_RST);
        rst_b = 1'b0;
        tick();
        check_reset_b("rst_mid");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
